// File: rtl/anapad_pkg.sv
// Shared types and helpers for the analog pad-bus sequencers.
package anapad_pkg;

  localparam int unsigned ANAPAD_MAX_REQ = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BBM_IN,
    ST_SETTLE,
    ST_GRANTED,
    ST_BBM_OUT
  } anapad_state_e;

  // Lowest index at or above ptr (wrapping at n) whose request is set.
  function automatic int unsigned rr_pick(input logic [ANAPAD_MAX_REQ-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < ANAPAD_MAX_REQ; k++) begin
      idx = (ptr + k) % n;
      if (!found && (k < n) && req[idx[2:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/anapad_rr_arb.sv
// Combinational round-robin picker with a registered priority pointer.
module anapad_rr_arb
  import anapad_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned OW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_adv,
  input  logic [OW-1:0]      i_adv_idx,
  output logic               o_any,
  output logic [OW-1:0]      o_pick
);

  logic [OW-1:0]             r_ptr;
  logic [ANAPAD_MAX_REQ-1:0] w_req_ext;

  always_comb begin
    w_req_ext                = '0;
    w_req_ext[NUM_REQ-1:0]   = i_req;
    o_pick = OW'(rr_pick(w_req_ext, 32'(r_ptr), NUM_REQ));
  end

  assign o_any = |i_req;

  // The pointer moves past the index that just released ownership.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (i_adv_idx == OW'(NUM_REQ - 1)) ? '0 : i_adv_idx + OW'(1);
    end
  end

endmodule

// File: rtl/anapad_mux_ctrl.sv
// Pad-bus switch sequencer: break-before-make, settle, grant, optional hold watchdog.
module anapad_mux_ctrl
  import anapad_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned BBM_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned MAX_HOLD      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_i,
  output logic [NUM_REQ-1:0]         sw_en_o,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       hold_err_o
);

  localparam int unsigned OW   = $clog2(NUM_REQ);
  localparam int unsigned CM0  = (BBM_CYCLES > SETTLE_CYCLES) ? BBM_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CMAX = (CM0 > MAX_HOLD) ? CM0 : MAX_HOLD;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] BBM_LD    = CW'(BBM_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  anapad_state_e      r_state;
  logic [CW-1:0]      r_cnt;
  logic [OW-1:0]      r_owner;
  logic [NUM_REQ-1:0] r_sw_en;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_busy;
  logic               r_hold_err;
  logic [NUM_REQ-1:0] r_needs_drop;

  logic [NUM_REQ-1:0] w_req_elig;
  logic [NUM_REQ-1:0] w_own_oh;
  logic               w_own_req;
  logic               w_hold_exp;
  logic               w_wd;
  logic               w_adv;
  logic               w_any;
  logic [OW-1:0]      w_pick;

  always_comb begin
    w_own_oh          = '0;
    w_own_oh[r_owner] = 1'b1;
    w_own_req         = req_i[r_owner];
    w_req_elig        = req_i & ~r_needs_drop;
    w_hold_exp        = (MAX_HOLD != 0) && (r_cnt == '0);
    w_wd              = (r_state == ST_GRANTED) && w_own_req && w_hold_exp;
    w_adv             = (r_state == ST_GRANTED) && (!w_own_req || w_hold_exp);
  end

  anapad_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .OW      (OW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_req_elig),
    .i_adv     (w_adv),
    .i_adv_idx (r_owner),
    .o_any     (w_any),
    .o_pick    (w_pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_owner      <= '0;
      r_sw_en      <= '0;
      r_gnt        <= '0;
      r_busy       <= 1'b0;
      r_hold_err   <= 1'b0;
      r_needs_drop <= '0;
    end else begin
      r_hold_err   <= w_wd;
      // A watchdog-preempted requester is masked until it lowers its request.
      r_needs_drop <= (r_needs_drop & req_i) | (w_wd ? w_own_oh : '0);
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner <= w_pick;
            r_cnt   <= BBM_LD;
            r_busy  <= 1'b1;
            r_state <= ST_BBM_IN;
          end
        end
        ST_BBM_IN: begin
          if (!w_own_req) begin
            r_cnt   <= BBM_LD;
            r_state <= ST_BBM_OUT;
          end else if (r_cnt == '0) begin
            r_sw_en <= w_own_oh;
            r_cnt   <= SETTLE_LD;
            r_state <= ST_SETTLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_SETTLE: begin
          if (!w_own_req) begin
            r_sw_en <= '0;
            r_cnt   <= BBM_LD;
            r_state <= ST_BBM_OUT;
          end else if (r_cnt == '0) begin
            r_gnt   <= w_own_oh;
            r_cnt   <= HOLD_LD;
            r_state <= ST_GRANTED;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_GRANTED: begin
          if (w_adv) begin
            r_sw_en <= '0;
            r_gnt   <= '0;
            r_cnt   <= BBM_LD;
            r_state <= ST_BBM_OUT;
          end else if (MAX_HOLD != 0) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_BBM_OUT: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_sw_en <= '0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sw_en_o    = r_sw_en;
  assign gnt_o      = r_gnt;
  assign busy_o     = r_busy;
  assign owner_o    = r_owner;
  assign hold_err_o = r_hold_err;

endmodule

// File: tb/tb_anapad_mux_ctrl.sv
// Self-checking bench for anapad_mux_ctrl: directed tables, corner sequences, random vs. timeline model.
module tb_anapad_mux_ctrl;

  localparam int N   = 4;
  localparam int BBM = 4;
  localparam int SET = 16;
  localparam int MH  = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_i = '0;
  logic [3:0] sw_en_o, gnt_o;
  logic       busy_o, hold_err_o;
  logic [1:0] owner_o;

  int n_vec = 0;
  int n_err = 0;

  anapad_mux_ctrl #(
    .NUM_REQ       (N),
    .BBM_CYCLES    (BBM),
    .SETTLE_CYCLES (SET),
    .MAX_HOLD      (MH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .sw_en_o    (sw_en_o),
    .gnt_o      (gnt_o),
    .busy_o     (busy_o),
    .owner_o    (owner_o),
    .hold_err_o (hold_err_o)
  );

  always #5 clk = ~clk;

  // Timeline reference model: ownership described by decision and release edge numbers.
  int         cyc;
  bit         m_busy;
  int         m_owner, m_t0, m_trel, m_ptr;
  logic [3:0] m_nd;
  logic [3:0] e_sw, e_gnt;
  logic       e_busy, e_herr;
  logic [1:0] e_owner;

  initial begin
    int         n, g, pick;
    logic [3:0] r, el;
    bit         wd;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc = 0; m_busy = 0; m_owner = 0; m_t0 = 0; m_trel = -1; m_ptr = 0; m_nd = '0;
        e_sw = '0; e_gnt = '0; e_busy = 0; e_herr = 0; e_owner = '0;
      end else begin
        cyc++; n = cyc; r = req_i; wd = 0;
        g = m_t0 + BBM + SET;
        if (!m_busy) begin
          el = r & ~m_nd;
          pick = -1;
          for (int k = 0; k < N; k++)
            if (pick < 0 && el[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
          if (pick >= 0) begin
            m_owner = pick; m_t0 = n; m_trel = -1; m_busy = 1;
          end
        end else if (m_trel < 0) begin
          if (!r[m_owner]) begin
            m_trel = n;
            if (n > g) m_ptr = (m_owner + 1) % N;
          end else if (n == g + MH) begin
            m_trel = n; m_ptr = (m_owner + 1) % N; wd = 1;
          end
        end else if (n == m_trel + BBM) begin
          m_busy = 0;
        end
        m_nd = (m_nd & r) | (wd ? (4'b0001 << m_owner) : 4'b0000);
        g = m_t0 + BBM + SET;
        e_busy  = m_busy;
        e_owner = m_owner[1:0];
        e_herr  = wd;
        e_sw  = (m_busy && n >= m_t0 + BBM && (m_trel < 0 || n < m_trel)) ? (4'b0001 << m_owner) : 4'b0000;
        e_gnt = (m_busy && n >= g && (m_trel < 0 || n < m_trel)) ? (4'b0001 << m_owner) : 4'b0000;
      end
    end
  end

  // Continuous comparison against the model plus the pad-safety invariants.
  initial begin
    int zrun;
    bit had;
    zrun = 0; had = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        zrun = 0; had = 0;
      end else begin
        n_vec++;
        if ({sw_en_o, gnt_o, busy_o, owner_o, hold_err_o} !== {e_sw, e_gnt, e_busy, e_owner, e_herr}) begin
          n_err++;
          $display("FAIL model cyc=%0d: sw=%b gnt=%b busy=%b own=%0d herr=%b, expected sw=%b gnt=%b busy=%b own=%0d herr=%b",
                   cyc, sw_en_o, gnt_o, busy_o, owner_o, hold_err_o, e_sw, e_gnt, e_busy, e_owner, e_herr);
        end
        n_vec++;
        if ($countones(sw_en_o) > 1 || (gnt_o & ~sw_en_o) != 4'b0000) begin
          n_err++;
          $display("FAIL onehot_subset: sw=%b gnt=%b, required onehot sw and gnt within sw", sw_en_o, gnt_o);
        end
        if (sw_en_o == 4'b0000) zrun++;
        else begin
          if (had && zrun > 0) begin
            n_vec++;
            if (zrun < BBM + 1) begin
              n_err++;
              $display("FAIL bbm_gap: %0d open cycles, required >= %0d", zrun, BBM + 1);
            end
          end
          had = 1; zrun = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    req_i = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < N; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  task automatic wait_gnt(output int idx, output int zeros);
    bit done;
    idx = -1; zeros = 0; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (sw_en_o == 4'b0000) zeros++;
      if (gnt_o != 4'b0000) begin
        idx = oh_idx(gnt_o);
        done = 1;
      end
    end
    if (!done) chk("gnt_timeout", 0, 1);
  endtask

  typedef struct {
    logic [3:0] req;
    int         ncyc;
    logic [3:0] sw;
    logic [3:0] gnt;
    logic       busy;
    int         owner;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int idx, zeros, cnt, bad;
    int exp_order[3];

    tbl[0] = '{4'b0000,  2, 4'b0000, 4'b0000, 1'b0, 0};
    tbl[1] = '{4'b0010,  1, 4'b0000, 4'b0000, 1'b1, 1};
    tbl[2] = '{4'b0010,  3, 4'b0000, 4'b0000, 1'b1, 1};
    tbl[3] = '{4'b0010,  1, 4'b0010, 4'b0000, 1'b1, 1};
    tbl[4] = '{4'b0010, 15, 4'b0010, 4'b0000, 1'b1, 1};
    tbl[5] = '{4'b0010,  1, 4'b0010, 4'b0010, 1'b1, 1};
    tbl[6] = '{4'b0010, 10, 4'b0010, 4'b0010, 1'b1, 1};
    tbl[7] = '{4'b0000,  1, 4'b0000, 4'b0000, 1'b1, 1};
    tbl[8] = '{4'b0000,  3, 4'b0000, 4'b0000, 1'b1, 1};
    tbl[9] = '{4'b0000,  1, 4'b0000, 4'b0000, 1'b0, 1};

    // Single requester timing table.
    do_reset();
    for (int t = 0; t < 10; t++) begin
      req_i = tbl[t].req;
      repeat (tbl[t].ncyc) @(negedge clk);
      chk($sformatf("tbl[%0d].sw", t),    int'(sw_en_o), int'(tbl[t].sw));
      chk($sformatf("tbl[%0d].gnt", t),   int'(gnt_o),   int'(tbl[t].gnt));
      chk($sformatf("tbl[%0d].busy", t),  int'(busy_o),  int'(tbl[t].busy));
      chk($sformatf("tbl[%0d].owner", t), int'(owner_o), tbl[t].owner);
    end
    chk("tbl.hold_err", int'(hold_err_o), 0);

    // Contention: three requesters served in round-robin order.
    exp_order = '{0, 1, 3};
    do_reset();
    req_i = 4'b1011;
    for (int o = 0; o < 3; o++) begin
      wait_gnt(idx, zeros);
      chk($sformatf("cont_owner%0d", o), idx, exp_order[o]);
      if (o > 0) chk($sformatf("cont_gap%0d_ok", o), int'(zeros >= BBM + 1), 1);
      repeat (9) @(negedge clk);
      if (idx >= 0) req_i[idx] = 1'b0;
    end
    repeat (BBM + 2) @(negedge clk);
    chk("cont_idle", int'(busy_o), 0);

    // Abort during settle.
    do_reset();
    req_i = 4'b0100;
    cnt = 0;
    while (!sw_en_o[2] && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("abort_sw_rise_cyc", cnt, BBM + 1);
    bad = 0;
    repeat (7) begin
      @(negedge clk);
      if (gnt_o != 4'b0000) bad++;
    end
    chk("abort_sw_before", int'(sw_en_o), 4);
    req_i = 4'b0000;
    @(negedge clk);
    chk("abort_sw_cleared", int'(sw_en_o), 0);
    chk("abort_busy_bbm", int'(busy_o), 1);
    repeat (3) begin
      @(negedge clk);
      if (gnt_o != 4'b0000) bad++;
    end
    chk("abort_busy_late", int'(busy_o), 1);
    @(negedge clk);
    chk("abort_idle", int'(busy_o), 0);
    chk("abort_no_gnt", bad, 0);

    // Watchdog: requester 1 holds forever, requester 0 waits.
    do_reset();
    req_i = 4'b0010;
    wait_gnt(idx, zeros);
    chk("wd_first_owner", idx, 1);
    req_i = 4'b0011;
    cnt = 1;
    while (gnt_o[1] && cnt < 100) begin
      @(negedge clk);
      if (gnt_o[1]) cnt++;
    end
    chk("wd_hold_len", cnt, MH);
    chk("wd_err_pulse", int'(hold_err_o), 1);
    @(negedge clk);
    chk("wd_err_once", int'(hold_err_o), 0);
    wait_gnt(idx, zeros);
    chk("wd_next_owner", idx, 0);
    repeat (5) @(negedge clk);
    req_i = 4'b0010;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (gnt_o[1]) bad++;
    end
    chk("wd_no_regrant", bad, 0);
    chk("wd_masked_idle", int'(busy_o), 0);
    req_i = 4'b0000;
    @(negedge clk);
    req_i = 4'b0010;
    wait_gnt(idx, zeros);
    chk("wd_regrant_after_toggle", idx, 1);
    req_i = 4'b0000;
    repeat (10) @(negedge clk);

    // Asynchronous reset while granted.
    do_reset();
    req_i = 4'b0001;
    wait_gnt(idx, zeros);
    chk("rst_pre_owner", idx, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_sw", int'(sw_en_o), 0);
    chk("rst_async_gnt", int'(gnt_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    idx = 0;
    while (idx == 0 && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (gnt_o != 4'b0000) idx = 1;
    end
    chk("rst_regrant_latency", cnt, 1 + BBM + SET);
    req_i = 4'b0000;
    repeat (10) @(negedge clk);

    // Random regression against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++)
        if ($urandom_range(39, 0) == 0) req_i[b] = ~req_i[b];
    end
    req_i = 4'b0000;
    repeat (60) @(negedge clk);
    chk("final_idle", int'(busy_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
